// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: four requesters share one FIFO write port,
// each grant lasting until req_last or MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [3:0]          req_valid,
  input  logic [4*DATA_W-1:0] req_data,
  input  logic [3:0]          req_last,
  output logic [3:0]          req_ready,
  input  logic                full,
  output logic                wen,
  output logic [DATA_W-1:0]   wdata,
  output logic [3:0]          grant,
  output logic [31:0]         word_cnt,
  output logic [15:0]         stall_cnt
);
  localparam int unsigned NREQ   = 4;
  localparam int unsigned BEAT_W = $clog2(MAX_BURST);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]       word_cnt_q, word_cnt_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic [1:0]        owner;
  logic [1:0]        pick;
  logic [1:0]        cand;
  logic              found;
  logic              owner_valid;
  logic              owner_last;
  logic [DATA_W-1:0] owner_data;
  logic              xfer;

  // Owner index and its request lines, decoded from the one-hot grant
  always_comb begin
    owner      = 2'd0;
    owner_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) begin
        owner      = 2'(i);
        owner_data = req_data[i*DATA_W +: DATA_W];
      end
    end
    owner_valid = req_valid[owner];
    owner_last  = req_last[owner];
  end

  // First valid requester searching upward from rr_ptr, modulo 4
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    cand  = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Reset gates the write path so nothing leaks out while rst is high
  assign xfer = (state_q == BURST) && owner_valid && !full && !rst;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    word_cnt_d  = word_cnt_q;
    stall_cnt_d = stall_cnt_q;
    wen         = 1'b0;
    req_ready   = '0;
    wdata       = '0;
    case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d    = BURST;
          grant_d    = NREQ'(1) << pick;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (xfer) begin
          wen        = 1'b1;
          req_ready  = grant_q;
          wdata      = owner_data;
          word_cnt_d = word_cnt_q + 32'd1;
          if (owner_last || (beat_cnt_q == BEAT_LAST)) begin
            state_d    = IDLE;
            grant_d    = '0;
            rr_ptr_d   = owner + 2'd1;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end else if (owner_valid && full && (stall_cnt_q != 16'hFFFF)) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= 2'd0;
      beat_cnt_q  <= '0;
      word_cnt_q  <= 32'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign word_cnt  = word_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round-robin order, burst limits,
// full stalls, en gating, mid-burst reset and word counter wrap.
module tb_fifo_wr_arbiter;
  localparam int unsigned DW = 16;
  localparam int unsigned MB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          full;
  logic          seq_clr;
  logic          last_en;
  logic [3:0]    req_valid;
  logic [3:0]    req_last;
  logic [3:0]    req_ready;
  logic [3:0]    grant;
  logic [4*DW-1:0] req_data;
  logic          wen;
  logic [DW-1:0] wdata;
  logic [31:0]   word_cnt;
  logic [15:0]   stall_cnt;
  logic [11:0]   seq [4];

  int n_checks = 0;
  int n_fail   = 0;
  int b;
  int ph;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .full      (full),
    .wen       (wen),
    .wdata     (wdata),
    .grant     (grant),
    .word_cnt  (word_cnt),
    .stall_cnt (stall_cnt)
  );

  // Requester sources: word = {id, sequence}; last on every 4th word when enabled
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (seq_clr) seq[i] <= 12'd0;
      else if (req_ready[i]) seq[i] <= seq[i] + 12'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_data[i*DW +: DW] = {4'(i), seq[i]};
      req_last[i]          = last_en & (seq[i][1:0] == 2'd3);
    end
  end

  function automatic logic [15:0] wd(input int r, input int k);
    return 16'(r * 4096 + k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string sc, input int c, input logic ew,
                         input logic [3:0] eg, input logic [15:0] ed);
    chk($sformatf("%s.c%0d.wen", sc, c), 32'(wen), 32'(ew));
    chk($sformatf("%s.c%0d.grant", sc, c), 32'(grant), 32'(eg));
    chk($sformatf("%s.c%0d.req_ready", sc, c), 32'(req_ready), ew ? 32'(eg) : 32'd0);
    if (ew) chk($sformatf("%s.c%0d.wdata", sc, c), 32'(wdata), 32'(ed));
  endtask

  // Two-cycle reset; returns at a falling edge with rst released
  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    req_valid = 4'b0000;
    full      = 1'b0;
    last_en   = 1'b0;
    seq_clr   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    seq_clr = 1'b0;
    rst     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state with requests pending
    rst = 1'b1; en = 1'b1; req_valid = 4'hF; full = 1'b0; last_en = 1'b1; seq_clr = 1'b1;
    @(negedge clk);
    #1;
    chk("RST.wen", 32'(wen), 32'd0);
    chk("RST.req_ready", 32'(req_ready), 32'd0);
    chk("RST.wdata", 32'(wdata), 32'd0);
    chk("RST.grant", 32'(grant), 32'd0);
    chk("RST.word_cnt", word_cnt, 32'd0);
    chk("RST.stall_cnt", 32'(stall_cnt), 32'd0);

    // A: all four valid, 4-beat bursts -> order 0,1,2,3,0 with one idle cycle between
    do_reset();
    en = 1'b1; last_en = 1'b1; req_valid = 4'hF;
    for (int c = 0; c <= 21; c++) begin
      #1;
      b  = c / 5;
      ph = c % 5;
      if (ph == 0) chk_out("A", c, 1'b0, 4'b0000, 16'h0);
      else chk_out("A", c, 1'b1, 4'(1 << (b % 4)), wd(b % 4, (b / 4) * 4 + ph - 1));
      if (c == 20) chk("A.word_cnt", word_cnt, 32'd16);
      @(negedge clk);
    end

    // B: requester 2 streams without last -> cut at 16 beats, pointer moves to 3
    do_reset();
    en = 1'b1; last_en = 1'b0; req_valid = 4'b0100;
    for (int c = 0; c <= 18; c++) begin
      if (c == 17) req_valid = 4'hF;
      #1;
      if (c >= 1 && c <= 16) chk_out("B", c, 1'b1, 4'b0100, wd(2, c - 1));
      else if (c == 18) chk_out("B", c, 1'b1, 4'b1000, wd(3, 0));
      else chk_out("B", c, 1'b0, 4'b0000, 16'h0);
      if (c == 17) begin
        chk("B.rr_ptr", 32'(dut.rr_ptr_q), 32'd3);
        chk("B.word_cnt", word_cnt, 32'd16);
      end
      @(negedge clk);
    end

    // C: full for 5 cycles mid-burst -> no writes, stall_cnt=5, no word lost
    do_reset();
    en = 1'b1; last_en = 1'b1; req_valid = 4'b0001;
    for (int c = 0; c <= 10; c++) begin
      full = (c >= 3 && c <= 7);
      #1;
      if (c == 1 || c == 2) chk_out("C", c, 1'b1, 4'b0001, wd(0, c - 1));
      else if (c == 8 || c == 9) chk_out("C", c, 1'b1, 4'b0001, wd(0, c - 6));
      else if (c >= 3 && c <= 7) chk_out("C", c, 1'b0, 4'b0001, 16'h0);
      else chk_out("C", c, 1'b0, 4'b0000, 16'h0);
      if (c == 5) chk("C.stall_mid", 32'(stall_cnt), 32'd2);
      if (c == 10) begin
        chk("C.stall_cnt", 32'(stall_cnt), 32'd5);
        chk("C.word_cnt", word_cnt, 32'd4);
      end
      @(negedge clk);
    end

    // D: en dropped at beat 2 -> burst completes, then no new grant
    do_reset();
    last_en = 1'b1; req_valid = 4'hF;
    for (int c = 0; c <= 8; c++) begin
      en = (c < 2);
      #1;
      if (c >= 1 && c <= 4) chk_out("D", c, 1'b1, 4'b0001, wd(0, c - 1));
      else chk_out("D", c, 1'b0, 4'b0000, 16'h0);
      if (c == 8) chk("D.word_cnt", word_cnt, 32'd4);
      @(negedge clk);
    end

    // E: reset at beat 3 of requester 3 -> write dropped at once, arbitration restarts at 0
    do_reset();
    en = 1'b1; last_en = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c < 5) ? 4'b0100 : 4'b1110;
      if (c == 9) rst = 1'b0;
      #1;
      if (c == 0 || c == 5 || c == 9) chk_out("E", c, 1'b0, 4'b0000, 16'h0);
      else if (c <= 4) chk_out("E", c, 1'b1, 4'b0100, wd(2, c - 1));
      else if (c <= 8) chk_out("E", c, 1'b1, 4'b1000, wd(3, c - 6));
      else chk_out("E", c, 1'b1, 4'b0010, wd(1, 0));
      if (c == 8) begin
        chk("E.word_cnt_pre", word_cnt, 32'd6);
        rst = 1'b1;
        #1;
        chk("E.rst_wen", 32'(wen), 32'd0);
        chk("E.rst_req_ready", 32'(req_ready), 32'd0);
        chk("E.rst_wdata", 32'(wdata), 32'd0);
        chk("E.rst_grant", 32'(grant), 32'd0);
        chk("E.rst_word_cnt", word_cnt, 32'd0);
      end
      @(negedge clk);
    end

    // F: word_cnt preset to 0xFFFFFFFE, three writes -> wraps to 1
    do_reset();
    en = 1'b1; last_en = 1'b0; req_valid = 4'b0001;
    force dut.word_cnt_q = 32'hFFFF_FFFE;
    #1;
    chk_out("F", 0, 1'b0, 4'b0000, 16'h0);
    @(posedge clk);
    #1;
    release dut.word_cnt_q;
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk_out("F", c, 1'b1, 4'b0001, wd(0, c - 1));
      chk($sformatf("F.c%0d.word_cnt", c), word_cnt, 32'hFFFF_FFFE + 32'(c - 1));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
